sl_result_reader: RTL and testbench

SL_RESULT_READER -- requirements
Module: sl_result_reader

---
 rtl/sl_result_reader.sv | 167 ++++++++++++++++
 tb/tb_sl_result_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_result_reader.sv
// sl_result_reader
// Holds DEPTH result entries of N x 4 bytes written by the second-layer
// datapath and streams a burst of consecutive entries out one byte at a time
// over a valid/ready handshake. Byte order within an entry is filter 0..N-1,
// and within each filter lane 0..3. Entry addresses wrap modulo DEPTH.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        asynchronous active-low reset
//   wr_en_i       write strobe; writes all bytes of entry wr_addr_i
//   wr_addr_i     entry address to write
//   wr_data_i     entry bytes, byte [filter][lane] at bits (filter*4+lane)*8 +: 8
//   start_i       single-cycle burst request (ignored unless idle)
//   base_addr_i   first entry of the burst, sampled on start_i
//   count_i       number of entries in the burst (0..DEPTH), sampled on start_i
//   out_data_o    streamed byte
//   out_filter_o  filter index of out_data_o
//   out_lane_o    lane index of out_data_o
//   out_valid_o   streamed byte and its tags are valid
//   out_ready_i   consumer accepts the byte when high together with out_valid_o
//   out_last_o    final byte of the burst
//   busy_o        burst in progress
//   done_o        one-cycle pulse when a burst completes
//   unwritten_o   sticky: the burst read an entry not written since reset
module sl_result_reader #(
  parameter int N     = 4,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH),
  localparam int FW   = (N > 1) ? $clog2(N) : 1,
  localparam int WW   = N * 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [WW-1:0] wr_data_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [7:0]    count_i,
  output logic [7:0]    out_data_o,
  output logic [FW-1:0] out_filter_o,
  output logic [1:0]    out_lane_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          unwritten_o
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_e;

  state_e state_q, state_d;

  logic [WW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [WW-1:0]    hold_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       remain_q;
  logic [FW-1:0]    filt_q;
  logic [1:0]       lane_q;
  logic             unwritten_q;

  logic load_burst;
  logic do_fetch;
  logic accept;
  logic last_in_entry;
  logic [FW+1:0] byte_sel;

  // Lane is two bits, so {filter, lane} is exactly filter*4 + lane.
  assign byte_sel = {filt_q, lane_q};

  always_comb begin
    state_d       = state_q;
    load_burst    = 1'b0;
    do_fetch      = 1'b0;
    accept        = (state_q == STREAM) && out_ready_i;
    last_in_entry = (filt_q == FW'(N - 1)) && (lane_q == 2'd3);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != 8'd0) begin
            load_burst = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        do_fetch = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        if (accept && last_in_entry) begin
          state_d = (remain_q == 8'd1) ? FINISH : FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array contents are not reset so the storage maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      written_q   <= '0;
      hold_q      <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      filt_q      <= '0;
      lane_q      <= '0;
      unwritten_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en_i) begin
        written_q[wr_addr_i] <= 1'b1;
      end
      if (load_burst) begin
        addr_q      <= base_addr_i;
        remain_q    <= count_i;
        filt_q      <= '0;
        lane_q      <= '0;
        unwritten_q <= 1'b0;
      end
      // Non-blocking read: a same-edge write to this entry is not yet visible,
      // so the holding register captures the pre-write data.
      if (do_fetch) begin
        hold_q <= mem[addr_q];
        if (!written_q[addr_q]) begin
          unwritten_q <= 1'b1;
        end
      end
      if (accept) begin
        if (lane_q == 2'd3) begin
          lane_q <= 2'd0;
          if (last_in_entry) begin
            filt_q   <= '0;
            remain_q <= remain_q - 8'd1;
            addr_q   <= addr_q + 1'b1;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end else begin
          lane_q <= lane_q + 2'd1;
        end
      end
    end
  end

  assign out_data_o   = hold_q[{byte_sel, 3'b000} +: 8];
  assign out_filter_o = filt_q;
  assign out_lane_o   = lane_q;
  assign out_valid_o  = (state_q == STREAM);
  assign out_last_o   = (state_q == STREAM) && last_in_entry && (remain_q == 8'd1);
  assign busy_o       = (state_q == FETCH) || (state_q == STREAM);
  assign done_o       = (state_q == FINISH);
  assign unwritten_o  = unwritten_q;

endmodule

// File: tb/tb_sl_result_reader.sv
module tb_sl_result_reader;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [6:0]    wr_addr = '0;
  logic [N*32-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [6:0]    base_addr = '0;
  logic [7:0]    count = '0;
  logic [7:0]    out_data;
  logic [1:0]    out_filter;
  logic [1:0]    out_lane;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          unwritten;

  always #5 clk = ~clk;

  sl_result_reader #(.N(N), .DEPTH(128)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .out_data_o  (out_data),
    .out_filter_o(out_filter),
    .out_lane_o  (out_lane),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done),
    .unwritten_o (unwritten)
  );

  typedef struct {
    logic [7:0] d;
    int         f;
    int         l;
    bit         last;
    bit         chk;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [128][16];
  bit         mwr [128];
  bit         model_unw = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         rmode = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    bit pat[4];
    int ph;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ph  = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = pat[ph % 4]; ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability
  // and the done pulse that must follow the last byte.
  initial begin
    bit         stall_prev;
    bit         last_prev;
    bit         done_prev;
    logic [7:0] hd;
    logic [1:0] hf;
    logic [1:0] hl;
    logic       hlast;
    exp_t       e;
    stall_prev = 0; last_prev = 0; done_prev = 0;
    hd = '0; hf = '0; hl = '0; hlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0; last_prev = 0; done_prev = 0;
      end else begin
        if (last_prev) check("done_after_last", int'(done), 1);
        if (done) begin
          done_cnt++;
          check("done_one_cycle", int'(done_prev), 0);
        end
        if (stall_prev) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(hd));
          check("stall_filter", int'(out_filter), int'(hf));
          check("stall_lane", int'(out_lane), int'(hl));
          check("stall_last", int'(out_last), int'(hlast));
        end
        if (out_valid) begin
          check("busy_in_stream", int'(busy), 1);
          if (out_ready) begin
            if (sbq.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_byte @%0t: got data %0d with no byte expected", $time, out_data);
            end else begin
              e = sbq.pop_front();
              if (e.chk) check("byte_data", int'(out_data), int'(e.d));
              check("byte_filter", int'(out_filter), e.f);
              check("byte_lane", int'(out_lane), e.l);
              check("byte_last", int'(out_last), int'(e.last));
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        hd = out_data; hf = out_filter; hl = out_lane; hlast = out_last;
        last_prev = out_valid && out_ready && out_last;
        done_prev = done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic write_entry(input int a, input bit rnd);
    logic [7:0] v;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      v = rnd ? 8'($urandom) : 8'(16 * a + i);
      mdl[a][i] = v;
      wr_data[i*8 +: 8] = v;
    end
    mwr[a]  = 1'b1;
    wr_addr = 7'(a);
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic push_burst(input int base, input int cnt);
    exp_t e;
    bit   unw;
    int   a;
    unw = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      a = (base + k) % 128;
      if (!mwr[a]) unw = 1'b1;
      for (int f = 0; f < 4; f++) begin
        for (int l = 0; l < 4; l++) begin
          e.d    = mdl[a][f*4 + l];
          e.f    = f;
          e.l    = l;
          e.last = (k == cnt - 1) && (f == 3) && (l == 3);
          e.chk  = mwr[a];
          sbq.push_back(e);
        end
      end
    end
    if (cnt > 0) model_unw = unw;
  endtask

  task automatic issue_start(input int base, input int cnt);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 7'(base);
    count     = 8'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input int base, input int cnt, input bit cw, input logic [7:0] cwv);
    int d0;
    int budget;
    push_burst(base, cnt);
    d0 = done_cnt;
    issue_start(base, cnt);
    check("busy_after_start", int'(busy), (cnt > 0) ? 1 : 0);
    if (cw) begin
      // Write lands on the same edge that the FETCH reads this entry.
      for (int i = 0; i < 16; i++) begin
        mdl[base][i] = cwv ^ 8'(i);
        wr_data[i*8 +: 8] = cwv ^ 8'(i);
      end
      mwr[base] = 1'b1;
      wr_addr   = 7'(base);
      wr_en     = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
    end
    budget = (cnt == 0) ? 2 : cnt * 16 * 8 + 20;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    check("done_pulse", done_cnt - d0, 1);
    check("sb_empty", sbq.size(), 0);
    check("unwritten", int'(unwritten), int'(model_unw));
    sbq.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_unwritten", int'(unwritten), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_filter", int'(out_filter), 0);
    check("rst_lane", int'(out_lane), 0);
  endtask

  initial begin
    int d0;
    for (int a = 0; a < 128; a++) mwr[a] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Directed: entries 0..3 with 16*addr + 4*filter + lane.
    for (int a = 0; a < 4; a++) write_entry(a, 1'b0);
    rmode = 0;
    run_burst(0, 4, 1'b0, 8'h00);
    rmode = 1;
    run_burst(0, 4, 1'b0, 8'h00);
    rmode = 0;

    // Address wrap 126, 127, 0.
    write_entry(126, 1'b1);
    write_entry(127, 1'b1);
    write_entry(0, 1'b1);
    run_burst(126, 3, 1'b0, 8'h00);

    // Never-written entry, then an empty burst.
    run_burst(5, 1, 1'b0, 8'h00);
    run_burst(0, 0, 1'b0, 8'h00);

    // Same-cycle write during FETCH, then rerun.
    write_entry(2, 1'b1);
    run_burst(2, 1, 1'b1, 8'hA5);
    run_burst(2, 1, 1'b0, 8'h00);

    // Randomized bursts with random backpressure.
    for (int t = 0; t < 8; t++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) write_entry(int'($urandom_range(0, 127)), 1'b1);
      rmode = 2;
      run_burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 6)), 1'b0, 8'h00);
    end
    rmode = 0;
    run_burst(int'($urandom_range(0, 127)), 128, 1'b0, 8'h00);

    // Reset mid-STREAM.
    for (int a = 0; a < 4; a++) write_entry(a, 1'b0);
    push_burst(0, 4);
    issue_start(0, 4);
    for (int i = 0; i < 500 && sbq.size() > 40; i++) @(posedge clk);
    check("reached_mid_stream", int'(sbq.size() <= 40), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    for (int a = 0; a < 128; a++) mwr[a] = 1'b0;
    model_unw = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_reset", done_cnt - d0, 0);
    rst_n = 1'b1;
    run_burst(0, 2, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
